// File: rtl/instr_mem_loader.sv
// instr_mem_loader: byte-addressed instruction memory with a big-endian word loader and combinational read port
module instr_mem_loader #(
   parameter int          MEM_BYTES  = 1000,
   parameter logic [31:0] START_ADDR = 32'd0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_valid,
   output logic        wr_ready,
   input  logic [31:0] wr_data,
   input  logic        wr_last,
   input  logic [31:0] rd_address,
   output logic [31:0] rd_instruction,
   output logic        load_done,
   output logic        load_error,
   output logic [15:0] words_loaded
);
   localparam int AW = MEM_BYTES > 1 ? $clog2(MEM_BYTES) : 1;
   typedef enum logic [1:0] {ACCEPT, WRITE, DONE, ERROR} state_t;
   state_t      state_q;
   logic [31:0] wptr_q, data_q;
   logic [1:0]  cnt_q;
   logic        last_q, ready_q, done_q, err_q;
   logic [15:0] words_q;
   logic [7:0]  mem_q [MEM_BYTES];
   logic [7:0]  wbyte;
   logic        ovf;
   assign ovf   = ({1'b0, wptr_q} + 33'd3) >= 33'(MEM_BYTES);
   assign wbyte = cnt_q == 2'd0 ? data_q[31:24] :
                  cnt_q == 2'd1 ? data_q[23:16] :
                  cnt_q == 2'd2 ? data_q[15:8]  : data_q[7:0];
   assign wr_ready     = ready_q;
   assign load_done    = done_q;
   assign load_error   = err_q;
   assign words_loaded = words_q;
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ACCEPT;
         wptr_q  <= START_ADDR;
         cnt_q   <= 2'd0;
         words_q <= 16'd0;
         ready_q <= 1'b1;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         case (state_q)
            ACCEPT: if (wr_valid) begin
               data_q  <= wr_data;
               last_q  <= wr_last;
               cnt_q   <= 2'd0;
               ready_q <= 1'b0;
               err_q   <= ovf;
               state_q <= ovf ? ERROR : WRITE;
            end
            WRITE: begin
               cnt_q <= cnt_q + 2'd1;
               if (cnt_q == 2'd3) begin
                  wptr_q  <= wptr_q + 32'd4;
                  words_q <= words_q == 16'hFFFF ? words_q : words_q + 16'd1;
                  done_q  <= last_q;
                  ready_q <= !last_q;
                  state_q <= last_q ? DONE : ACCEPT;
               end
            end
            DONE:  state_q <= DONE;
            ERROR: state_q <= ERROR;
         endcase
      end
   end
   // Memory has no reset; a reset edge never completes a pending byte write.
   always_ff @(posedge clk)
      if (!rst && state_q == WRITE) mem_q[wptr_q[AW-1:0] + AW'(cnt_q)] <= wbyte;
   for (genvar i = 0; i < 4; i++) begin : g_rd
      logic [32:0] a;
      assign a = {1'b0, rd_address} + 33'(i);
      assign rd_instruction[31-8*i -: 8] = a < 33'(MEM_BYTES) ? mem_q[a[AW-1:0]] : 8'h00;
   end
endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader: directed checks of load, backpressure, overflow, reset and read-port behaviour
module tb_instr_mem_loader;
   logic        clk = 1'b0;
   logic        rst_a, v_a, l_a, rdy_a, done_a, err_a;
   logic [31:0] d_a, ra_a, ins_a;
   logic [15:0] wl_a;
   logic        rst_b, v_b, l_b, rdy_b, done_b, err_b;
   logic [31:0] d_b, ra_b, ins_b;
   logic [15:0] wl_b;
   int          checks = 0, errors = 0, k;
   int          hs[3];
   logic        h;
   always #5 clk = ~clk;
   instr_mem_loader #(.MEM_BYTES(1000)) dut (
      .clk(clk), .rst(rst_a), .wr_valid(v_a), .wr_ready(rdy_a), .wr_data(d_a), .wr_last(l_a),
      .rd_address(ra_a), .rd_instruction(ins_a), .load_done(done_a), .load_error(err_a),
      .words_loaded(wl_a));
   instr_mem_loader #(.MEM_BYTES(8)) dut8 (
      .clk(clk), .rst(rst_b), .wr_valid(v_b), .wr_ready(rdy_b), .wr_data(d_b), .wr_last(l_b),
      .rd_address(ra_b), .rd_instruction(ins_b), .load_done(done_b), .load_error(err_b),
      .words_loaded(wl_b));
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic send(input bit b, input logic [31:0] d, input bit last);
      int n = 0;
      if (b) begin v_b = 1; d_b = d; l_b = last; end
      else begin v_a = 1; d_a = d; l_a = last; end
      while (!(b ? rdy_b : rdy_a) && n < 20) begin step(); n++; end
      if (n == 20) chk("send_ready_timeout", 32'(b ? rdy_b : rdy_a), 32'd1);
      step();
      if (b) v_b = 0; else v_a = 0;
      repeat (4) step();
   endtask
   initial begin
      rst_a = 1; v_a = 0; d_a = 0; l_a = 0; ra_a = 0;
      rst_b = 1; v_b = 0; d_b = 0; l_b = 0; ra_b = 0;
      step();
      rst_a = 0; rst_b = 0;
      chk("rst_ready", 32'(rdy_a), 32'd1);
      chk("rst_done", 32'(done_a), 32'd0);
      chk("rst_error", 32'(err_a), 32'd0);
      chk("rst_words", {16'd0, wl_a}, 32'd0);
      v_a = 1; d_a = 32'h8C220004; l_a = 1;
      step();
      v_a = 0;
      chk("single_busy", 32'(rdy_a), 32'd0);
      repeat (3) step();
      chk("single_done_early", 32'(done_a), 32'd0);
      step();
      chk("single_rd0", ins_a, 32'h8C220004);
      chk("single_done", 32'(done_a), 32'd1);
      chk("single_words", {16'd0, wl_a}, 32'd1);
      v_a = 1; d_a = 32'hFFFFFFFF; l_a = 0;
      for (int c = 0; c < 10; c++) begin
         step();
         chk("done_ready", 32'(rdy_a), 32'd0);
      end
      v_a = 0;
      chk("done_mem", ins_a, 32'h8C220004);
      chk("done_words", {16'd0, wl_a}, 32'd1);
      rst_a = 1; step(); rst_a = 0;
      chk("rst2_words", {16'd0, wl_a}, 32'd0);
      chk("rst2_done", 32'(done_a), 32'd0);
      k = 0; v_a = 1; d_a = 32'h11111111; l_a = 0;
      for (int c = 0; c < 20; c++) begin
         h = v_a && rdy_a;
         if (h) hs[k] = c;
         step();
         if (h) begin
            k++;
            d_a = k == 1 ? 32'h22222222 : 32'h33333333;
            l_a = k == 2;
            v_a = k < 3;
         end
      end
      chk("stream_handshakes", k, 3);
      chk("stream_gap1", hs[1] - hs[0], 5);
      chk("stream_gap2", hs[2] - hs[1], 5);
      chk("stream_words", {16'd0, wl_a}, 32'd3);
      chk("stream_done", 32'(done_a), 32'd1);
      ra_a = 8; #1 chk("stream_rd8", ins_a, 32'h33333333);
      ra_a = 2; #1 chk("stream_rd2", ins_a, 32'h11112222);
      ra_a = 4; #1 chk("stream_rd4", ins_a, 32'h22222222);
      ra_a = 0;
      rst_a = 1; step(); rst_a = 0;
      v_a = 1; d_a = 32'hAABBCCDD; l_a = 0;
      step();
      v_a = 0;
      step(); step();
      rst_a = 1; step(); rst_a = 0;
      chk("midrst_bytes01", {16'd0, ins_a[31:16]}, 32'h0000AABB);
      chk("midrst_words", {16'd0, wl_a}, 32'd0);
      chk("midrst_ready", 32'(rdy_a), 32'd1);
      send(0, 32'h01020304, 1);
      chk("midrst_reload", ins_a, 32'h01020304);
      chk("midrst_words2", {16'd0, wl_a}, 32'd1);
      rst_a = 1; v_a = 1; d_a = 32'hDEADBEEF; l_a = 1;
      step();
      rst_a = 0; v_a = 0;
      chk("rst_hs_ready", 32'(rdy_a), 32'd1);
      repeat (5) step();
      chk("rst_hs_mem", ins_a, 32'h01020304);
      chk("rst_hs_words", {16'd0, wl_a}, 32'd0);
      for (int i = 0; i < 250; i++) send(0, {8'(i), 8'(i + 1), ~8'(i), 8'h5A}, i == 249);
      chk("full_words", {16'd0, wl_a}, 32'd250);
      chk("full_done", 32'(done_a), 32'd1);
      chk("full_error", 32'(err_a), 32'd0);
      ra_a = 996;  #1 chk("full_rd996", ins_a, 32'hF9FA065A);
      ra_a = 998;  #1 chk("oor_rd998", ins_a, 32'h065A0000);
      ra_a = 999;  #1 chk("oor_rd999", ins_a, 32'h5A000000);
      ra_a = 1000; #1 chk("oor_rd1000", ins_a, 32'h00000000);
      ra_a = 4;    #1 chk("full_rd4", ins_a, 32'h01020000 | 32'h0000FE5A);
      send(1, 32'h11223344, 0);
      send(1, 32'h55667788, 0);
      chk("ovf_words2", {16'd0, wl_b}, 32'd2);
      chk("ovf_ready", 32'(rdy_b), 32'd1);
      v_b = 1; d_b = 32'h99999999; l_b = 0;
      step();
      v_b = 0;
      chk("ovf_error", 32'(err_b), 32'd1);
      chk("ovf_busy", 32'(rdy_b), 32'd0);
      repeat (5) step();
      chk("ovf_words", {16'd0, wl_b}, 32'd2);
      chk("ovf_sticky", 32'(err_b), 32'd1);
      ra_b = 0; #1 chk("ovf_rd0", ins_b, 32'h11223344);
      ra_b = 4; #1 chk("ovf_rd4", ins_b, 32'h55667788);
      ra_b = 6; #1 chk("ovf_rd6", ins_b, 32'h77880000);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
